// File: rtl/timer_wavegen.sv
// Timer/counter with output-compare waveform generator: normal, CTC, fast PWM and
// phase-correct PWM modes with AVR-style compare-output actions on the oc pin.
module timer_wavegen #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tick,
  input  logic [1:0]       wgm,
  input  logic [1:0]       com,
  input  logic             ocr_we,
  input  logic [WIDTH-1:0] ocr_wdata,
  input  logic             tcnt_we,
  input  logic [WIDTH-1:0] tcnt_wdata,
  input  logic             foc,
  output logic [WIDTH-1:0] tcnt,
  output logic [WIDTH-1:0] ocr_rdata,
  output logic             oc,
  output logic             oc_oe,
  output logic             match,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    WGM_NORMAL = 2'b00,
    WGM_PHASE  = 2'b01,
    WGM_CTC    = 2'b10,
    WGM_FAST   = 2'b11
  } wgm_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  wgm_e mode;
  assign mode = wgm_e'(wgm);

  logic [WIDTH-1:0] tcnt_q, tcnt_d;
  logic [WIDTH-1:0] ocr_buf_q, ocr_buf_d;
  logic [WIDTH-1:0] ocr_act_q, ocr_act_d;
  dir_e             dir_q, dir_d;
  logic             inhibit_q, inhibit_d;
  logic             oc_q, oc_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;

  logic             pwm;
  logic             count_ev;
  logic             cmp_hit;
  logic             match_ev;
  logic             bottom_ev;
  logic             ovf_ev;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] cnt_next;
  dir_e             dir_next;

  always_comb begin
    pwm       = (mode == WGM_PHASE) || (mode == WGM_FAST);
    at_max    = (tcnt_q == MAX);
    at_zero   = (tcnt_q == '0);
    count_ev  = tick && !tcnt_we;
    cmp_hit   = (tcnt_q == ocr_act_q) && !inhibit_q;
    match_ev  = count_ev && cmp_hit;
    bottom_ev = count_ev && at_max;

    cnt_next = tcnt_q + ONE;
    dir_next = DIR_UP;
    case (mode)
      WGM_CTC: begin
        if (cmp_hit) cnt_next = '0;
      end
      WGM_PHASE: begin
        dir_next = dir_q;
        if (dir_q == DIR_UP) begin
          if (at_max) begin
            cnt_next = MAX - ONE;
            dir_next = DIR_DOWN;
          end
        end else if (at_zero) begin
          cnt_next = ONE;
          dir_next = DIR_UP;
        end else begin
          cnt_next = tcnt_q - ONE;
        end
      end
      default: ;
    endcase

    // Phase-correct overflows at BOTTOM on the way down; the other modes at TOP.
    if (mode == WGM_PHASE) ovf_ev = count_ev && at_zero && (dir_q == DIR_DOWN);
    else                   ovf_ev = count_ev && at_max;

    tcnt_d    = tcnt_q;
    dir_d     = (mode == WGM_PHASE) ? dir_q : DIR_UP;
    inhibit_d = inhibit_q;
    if (tcnt_we) begin
      tcnt_d    = tcnt_wdata;
      inhibit_d = 1'b1;
    end else if (tick) begin
      tcnt_d    = cnt_next;
      dir_d     = dir_next;
      inhibit_d = 1'b0;
    end

    ocr_buf_d = ocr_buf_q;
    ocr_act_d = ocr_act_q;
    if (ocr_we) begin
      ocr_buf_d = ocr_wdata;
      if (!pwm) ocr_act_d = ocr_wdata;
    end
    if (pwm && bottom_ev) ocr_act_d = ocr_buf_q;

    oc_d = oc_q;
    case (mode)
      WGM_FAST: begin
        // BOTTOM wins over a coincident match so ocr==MAX gives a flat output.
        if (com[1]) begin
          if (bottom_ev)     oc_d = ~com[0];
          else if (match_ev) oc_d = com[0];
        end
      end
      WGM_PHASE: begin
        if (com[1] && match_ev) oc_d = (cnt_next > tcnt_q) ? com[0] : ~com[0];
      end
      default: begin
        if (match_ev || foc) begin
          case (com)
            2'b01:   oc_d = ~oc_q;
            2'b10:   oc_d = 1'b0;
            2'b11:   oc_d = 1'b1;
            default: oc_d = oc_q;
          endcase
        end
      end
    endcase

    match_d = match_ev;
    ovf_d   = ovf_ev;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tcnt_q    <= '0;
      ocr_buf_q <= '0;
      ocr_act_q <= '0;
      dir_q     <= DIR_UP;
      inhibit_q <= 1'b0;
      oc_q      <= 1'b0;
      match_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      ocr_buf_q <= ocr_buf_d;
      ocr_act_q <= ocr_act_d;
      dir_q     <= dir_d;
      inhibit_q <= inhibit_d;
      oc_q      <= oc_d;
      match_q   <= match_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tcnt      = tcnt_q;
  assign ocr_rdata = ocr_buf_q;
  assign oc        = oc_q;
  assign oc_oe     = pwm ? com[1] : (com != 2'b00);
  assign match     = match_q;
  assign ovf       = ovf_q;

endmodule
